mem_access_seq: RTL and testbench

Memory-stage access sequencer: the initiator side of the byte-wide memory controller's MEM port. It accepts one load or store (byte/half/word, signed/unsigned) from the MEM pipeline stage and splits it into sequential single-byte requests toward the memory controller. For loads it gathers the returned bytes little-endian, extends the result, and reports completion with a one-cycle `done_o` pulse. MEM-port requests have priority in the memory controller, so this block never waits for a grant.

---
 rtl/mem_access_seq_pkg.sv | 26 ++
 rtl/mem_access_seq_load_ext.sv | 20 ++
 rtl/mem_access_seq.sv | 127 ++++++++++++
 tb/tb_mem_access_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_seq_pkg.sv
// rtl/mem_access_seq_pkg.sv - shared size codes, FSM encoding and constants for mem_access_seq
package mem_access_seq_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TAIL   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Size code 11 is treated as a word, same as 10.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_load_ext.sv
// rtl/mem_access_seq_load_ext.sv - sign/zero extension of assembled load data
module mem_load_ext
    import mem_access_seq_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    always_comb begin
        result = data;
        case (size)
            SZ_B:    result = {{24{~is_unsigned & data[7]}}, data[7:0]};
            SZ_H:    result = {{16{~is_unsigned & data[15]}}, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - MEM-stage sequencer splitting loads/stores into byte requests
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              mem_req_o,
    output logic              mem_r_w_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    input  logic [7:0]        mem_data_i
);

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       ext_data;
    logic [1:0]        lane;
    logic              last_addr;

    // Read data lags its address cycle by one, so it lands in lane cnt-1.
    assign lane      = cnt_q[1:0] - 2'd1;
    assign last_addr = (cnt_q == n_q - 3'd1);

    mem_load_ext u_load_ext (
        .data        (asm_q),
        .size        (funct3_q[1:0]),
        .is_unsigned (funct3_q[2]),
        .result      (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid_i) state_d = ST_ACCESS;
            ST_ACCESS: if (last_addr) state_d = store_q ? ST_DONE : ST_TAIL;
            ST_TAIL:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 3'd0;
            n_q      <= 3'd0;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= ZeroWord;
            asm_q    <= ZeroWord;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        store_q  <= req_store_i;
                        funct3_q <= req_funct3_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        n_q      <= size_bytes(req_funct3_i[1:0]);
                        cnt_q    <= 3'd0;
                        asm_q    <= ZeroWord;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (!store_q && cnt_q != 3'd0) begin
                        asm_q[{lane, 3'b000} +: 8] <= mem_data_i;
                    end
                end
                ST_TAIL: asm_q[{lane, 3'b000} +: 8] <= mem_data_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        rdata_o    = ZeroWord;
        mem_req_o  = 1'b0;
        mem_r_w_o  = 1'b0;
        mem_addr_o = '0;
        mem_data_o = 8'h00;
        case (state_q)
            ST_ACCESS: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_r_w_o  = store_q;
                mem_addr_o = addr_q + ADDR_W'(cnt_q);
                mem_data_o = store_q ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
            end
            ST_TAIL: busy_o = 1'b1;
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                if (!store_q) rdata_o = ext_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - self-checking bench for mem_access_seq
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_r_w;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_seq #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_store_i  (req_store),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .busy_o       (busy),
        .done_o       (done),
        .rdata_o      (rdata),
        .mem_req_o    (mem_req),
        .mem_r_w_o    (mem_r_w),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata)
    );

    // Byte-wide memory: writes at the address-cycle edge, read data one cycle later.
    logic [7:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_r_w) mem[mem_addr] = mem_wdata;
            else mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic        rw;
        logic [7:0]  d;
    } tr_t;
    tr_t trace[$];
    always @(negedge clk) if (mem_req) trace.push_back('{mem_addr, mem_r_w, mem_wdata});

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp;
        int          n;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] bytes);
        for (int j = 0; j < 4; j++) mem[a + 32'(j)] = bytes[8*j +: 8];
    endtask

    task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        trace.delete();
        @(negedge clk);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(output int done_k, output logic [31:0] rd);
        done_k = -1;
        rd     = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                done_k = k;
                rd     = rdata;
                break;
            end
        end
    endtask

    vec_t        vecs[10];
    int          done_k;
    logic [31:0] rd;
    int          done_seen;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h4433_2211, 32'h4433_2211, 4};
        vecs[1] = '{1'b0, 3'b000, 32'h0000_0300, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 1};
        vecs[2] = '{1'b0, 3'b100, 32'h0000_0300, 32'h0,         32'h0000_0080, 32'h0000_0080, 1};
        vecs[3] = '{1'b0, 3'b001, 32'h0000_0310, 32'h0,         32'h0000_7F80, 32'h0000_7F80, 2};
        vecs[4] = '{1'b0, 3'b001, 32'h0000_0320, 32'h0,         32'h0000_8000, 32'hFFFF_8000, 2};
        vecs[5] = '{1'b0, 3'b101, 32'h0000_0320, 32'h0,         32'h0000_8000, 32'h0000_8000, 2};
        vecs[6] = '{1'b1, 3'b001, 32'h0000_0201, 32'hDEAD_BEEF, 32'h5555_5555, 32'h0,         2};
        vecs[7] = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'hD4C3_B2A1, 32'hD4C3_B2A1, 4};
        vecs[8] = '{1'b1, 3'b010, 32'h0000_0400, 32'h0102_0304, 32'h0,         32'h0,         4};
        vecs[9] = '{1'b1, 3'b000, 32'h0000_0411, 32'h0000_00A5, 32'h6666_6666, 32'h0,         1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_mem_req", {31'b0, mem_req}, 32'h0);
        check("reset_mem_r_w", {31'b0, mem_r_w}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_data", {24'b0, mem_wdata}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v = vecs[i];
            preload(v.addr, v.init);
            start(v.store, v.f3, v.addr, v.wdata);
            wait_done(done_k, rd);
            check($sformatf("v%0d_done_cycle", i), 32'(done_k), 32'(v.store ? v.n + 1 : v.n + 2));
            check($sformatf("v%0d_rdata", i), rd, v.exp);
            check($sformatf("v%0d_nreq", i), 32'(trace.size()), 32'(v.n));
            for (int j = 0; j < trace.size() && j < 4; j++) begin
                check($sformatf("v%0d_addr%0d", i, j), trace[j].a, v.addr + 32'(j));
                check($sformatf("v%0d_rw%0d", i, j), {31'b0, trace[j].rw}, {31'b0, v.store});
                check($sformatf("v%0d_wbyte%0d", i, j), {24'b0, trace[j].d},
                      v.store ? {24'b0, v.wdata[8*j +: 8]} : 32'h0);
            end
            if (v.store) begin
                for (int j = 0; j < 4; j++) begin
                    check($sformatf("v%0d_mem%0d", i, j), {24'b0, mem[v.addr + 32'(j)]},
                          {24'b0, (j < v.n) ? v.wdata[8*j +: 8] : v.init[8*j +: 8]});
                end
            end
        end

        // Reset during A+2 of a word store to 0x40.
        preload(32'h40, 32'h0);
        done_seen = 0;
        start(1'b1, 3'b010, 32'h40, 32'hA1B2_C3D4);
        @(negedge clk);
        if (done) done_seen++;
        @(negedge clk);
        if (done) done_seen++;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mid_done", {31'b0, done}, 32'h0);
        check("rst_mid_addr", mem_addr, 32'h0);
        check("rst_mid_wdata", {24'b0, mem_wdata}, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || mem_req) done_seen++;
        end
        check("rst_mid_no_done", 32'(done_seen), 32'h0);
        check("rst_mid_mem40", {24'b0, mem[32'h40]}, 32'h0000_00D4);
        check("rst_mid_mem41", {24'b0, mem[32'h41]}, 32'h0000_00C3);
        check("rst_mid_mem42", {24'b0, mem[32'h42]}, 32'h0);
        check("rst_mid_mem43", {24'b0, mem[32'h43]}, 32'h0);

        // New request held from A+2 of a load: ignored until the cycle after DONE.
        preload(32'h100, 32'h4433_2211);
        preload(32'h500, 32'h8877_6655);
        start(1'b0, 3'b010, 32'h100, 32'h0);
        done_k = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) begin
                req_addr  = 32'h500;
                req_valid = 1'b1;
            end
            if (done) begin
                done_k = k;
                check("busy_rd_first", rdata, 32'h4433_2211);
            end
            if (k == 7) begin
                check("busy_accept_busy", {31'b0, busy}, 32'h0);
                check("busy_accept_mem_req", {31'b0, mem_req}, 32'h0);
            end
            if (k == 8) begin
                check("busy_next_mem_req", {31'b0, mem_req}, 32'h1);
                check("busy_next_addr", mem_addr, 32'h500);
            end
        end
        req_valid = 1'b0;
        check("busy_first_done_cycle", 32'(done_k), 32'd6);
        wait_done(done_k, rd);
        check("busy_second_done", 32'(done_k), 32'd5);
        check("busy_second_rdata", rd, 32'h8877_6655);
        check("busy_trace_len", 32'(trace.size()), 32'd8);
        for (int j = 0; j < trace.size() && j < 8; j++) begin
            check($sformatf("busy_addr%0d", j), trace[j].a,
                  (j < 4) ? 32'h100 + 32'(j) : 32'h500 + 32'(j - 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
